controle_partida: RTL and testbench

- Game-flow controller for Breakout. Sequences one match: idle, serve countdown, play, pause, miss handling and game over.
- Drives the scoreboard: a one-cycle `start` pulse clears the current score, and a one-cycle `score_inc` pulse is issued per distinct bar hit. Edge detection is centralised here.
- Gates ball motion through `ball_enable`, requests ball re-centring through `serve`, and tracks remaining lives.

---
 rtl/controle_partida.sv | 156 +++++++++++++++
 tb/tb_controle_partida.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/controle_partida.sv
// Breakout match sequencer: serve countdown, play/pause, miss handling and game over.
// Every output is a flop, and all button/hit/miss edge detection is done here.
module controle_partida #(
    parameter int LIVES       = 3,
    parameter int SERVE_TICKS = 60,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       hit_bar,
    input  logic       ball_missed,
    input  logic       tick,
    output logic       start,
    output logic       score_inc,
    output logic       ball_enable,
    output logic       serve,
    output logic       game_over,
    output logic [1:0] lives,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_MISS  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SERVE_TICKS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       r_lives;
    logic [1:0]       w_lives_next;
    logic             r_start;
    logic             w_start_next;
    logic             r_score_inc;
    logic             w_score_next;
    logic             r_ball_enable;
    logic             r_serve;
    logic             r_game_over;
    logic             r_btn_hist;
    logic             r_hit_hist;
    logic             r_miss_hist;

    logic w_rise_btn;
    logic w_rise_hit;
    logic w_rise_miss;

    assign w_rise_btn  = btn_start   & ~r_btn_hist;
    assign w_rise_hit  = hit_bar     & ~r_hit_hist;
    assign w_rise_miss = ball_missed & ~r_miss_hist;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lives_next = r_lives;
        w_start_next = 1'b0;
        w_score_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise_btn) begin
                    w_state_next = S_SERVE;
                    w_start_next = 1'b1;
                    w_lives_next = LIVES_INIT;
                    w_cnt_next   = '0;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = S_PLAY;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                // A miss swallows any coincident hit or pause request.
                if (w_rise_miss) begin
                    w_state_next = S_MISS;
                end else if (w_rise_btn) begin
                    w_state_next = S_PAUSE;
                end else if (w_rise_hit) begin
                    w_score_next = 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_rise_btn) begin
                    w_state_next = S_PLAY;
                end
            end
            S_MISS: begin
                w_lives_next = r_lives - 1'b1;
                w_cnt_next   = '0;
                w_state_next = (r_lives == 2'd1) ? S_OVER : S_SERVE;
            end
            S_OVER: begin
                if (w_rise_btn) begin
                    w_state_next = S_SERVE;
                    w_start_next = 1'b1;
                    w_lives_next = LIVES_INIT;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_lives       <= LIVES_INIT;
            r_start       <= 1'b0;
            r_score_inc   <= 1'b0;
            r_ball_enable <= 1'b0;
            r_serve       <= 1'b0;
            r_game_over   <= 1'b0;
            // History starts high so levels already asserted at release are not edges.
            r_btn_hist    <= 1'b1;
            r_hit_hist    <= 1'b1;
            r_miss_hist   <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_lives       <= w_lives_next;
            r_start       <= w_start_next;
            r_score_inc   <= w_score_next;
            r_ball_enable <= (w_state_next == S_PLAY);
            r_serve       <= (w_state_next == S_SERVE);
            r_game_over   <= (w_state_next == S_OVER);
            r_btn_hist    <= btn_start;
            r_hit_hist    <= hit_bar;
            r_miss_hist   <= ball_missed;
        end
    end

    assign start       = r_start;
    assign score_inc   = r_score_inc;
    assign ball_enable = r_ball_enable;
    assign serve       = r_serve;
    assign game_over   = r_game_over;
    assign lives       = r_lives;
    assign state       = r_state;

endmodule

// File: tb/tb_controle_partida.sv
// Directed bench for controle_partida with SERVE_TICKS=4; expectations are hand-derived.
module tb_controle_partida;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_start, hit_bar, ball_missed, tick;
    logic       start, score_inc, ball_enable, serve, game_over;
    logic [1:0] lives;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int score_cnt = 0;
    int start_base, score_base, hits;

    controle_partida #(.LIVES(3), .SERVE_TICKS(4), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_start   (btn_start),
        .hit_bar     (hit_bar),
        .ball_missed (ball_missed),
        .tick        (tick),
        .start       (start),
        .score_inc   (score_inc),
        .ball_enable (ball_enable),
        .serve       (serve),
        .game_over   (game_over),
        .lives       (lives),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (start)     start_cnt++;
            if (score_inc) score_cnt++;
        end
    endtask

    task automatic do_serve(input string tag);
        repeat (4) begin
            tick = 1'b1; step(1);
            tick = 1'b0; step(1);
        end
        check(tag, state, 2);
    endtask

    task automatic do_miss(input string tag, input int exp_lives, input int exp_state);
        ball_missed = 1'b1; step(1);
        check({tag, "_miss_state"}, state, 4);
        ball_missed = 1'b0; step(1);
        check({tag, "_lives"}, lives, exp_lives);
        check({tag, "_next_state"}, state, exp_state);
    endtask

    initial begin
        reset = 1'b0; btn_start = 1'b1; hit_bar = 1'b0; ball_missed = 1'b0; tick = 1'b0;
        step(2);
        check("rst_state", state, 0);
        check("rst_lives", lives, 3);
        check("rst_outs", {start, score_inc, ball_enable, serve, game_over}, 0);

        // Release with button held: no edge.
        reset = 1'b1; step(3);
        check("held_btn_state", state, 0);
        check("held_btn_start", start_cnt, 0);

        btn_start = 1'b0; step(1);
        btn_start = 1'b1; step(1);
        check("start_pulse", start, 1);
        check("start_state", state, 1);
        check("start_lives", lives, 3);
        check("start_serve", serve, 1);
        btn_start = 1'b0; step(1);
        check("start_one_cycle", start, 0);
        check("start_total", start_cnt, 1);

        // Serve countdown: ticks 5 cycles apart.
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("pre_tick%0d_ben", i), ball_enable, 0);
            tick = 1'b1; step(1);
            tick = 1'b0;
            check($sformatf("tick%0d_state", i), state, (i == 4) ? 2 : 1);
            check($sformatf("tick%0d_serve", i), serve, (i == 4) ? 0 : 1);
            check($sformatf("tick%0d_ben", i), ball_enable, (i == 4) ? 1 : 0);
            step(4);
        end

        // Held hit and a short hit: two pulses.
        score_base = score_cnt;
        hit_bar = 1'b1; step(10);
        hit_bar = 1'b0; step(1);
        hit_bar = 1'b1; step(1);
        hit_bar = 1'b0; step(2);
        hits = score_cnt - score_base;
        check("hit_pulses", hits, 2);
        check("hit_state", state, 2);

        // Simultaneous hit and miss: miss wins, no score.
        start_base = start_cnt;
        score_base = score_cnt;
        hit_bar = 1'b1; ball_missed = 1'b1; step(1);
        check("hitmiss_score", score_inc, 0);
        check("hitmiss_state", state, 4);
        hit_bar = 1'b0; ball_missed = 1'b0; step(1);
        check("miss1_lives", lives, 2);
        check("miss1_state", state, 1);
        do_serve("serve2");
        do_miss("m2", 1, 1);
        do_serve("serve3");
        do_miss("m3", 0, 5);
        check("over_flag", game_over, 1);
        check("over_ben", ball_enable, 0);
        check("over_no_start", start_cnt - start_base, 0);
        check("over_no_score", score_cnt - score_base, 0);

        // Tick in OVER has no effect.
        tick = 1'b1; step(1); tick = 1'b0;
        check("over_tick_state", state, 5);

        btn_start = 1'b1; step(1);
        check("restart_pulse", start, 1);
        check("restart_lives", lives, 3);
        check("restart_state", state, 1);
        check("restart_go", game_over, 0);
        btn_start = 1'b0; step(1);
        do_serve("serve4");

        // Pause: hit/miss ignored, hit level carried into PLAY gives no pulse.
        score_base = score_cnt;
        btn_start = 1'b1; step(1);
        check("pause_state", state, 3);
        check("pause_ben", ball_enable, 0);
        btn_start = 1'b0; hit_bar = 1'b1; step(1);
        ball_missed = 1'b1; step(1);
        check("pause_hold_state", state, 3);
        check("pause_lives", lives, 3);
        ball_missed = 1'b0; step(1);
        btn_start = 1'b1; step(1);
        check("resume_state", state, 2);
        check("resume_ben", ball_enable, 1);
        btn_start = 1'b0; step(2);
        check("pause_no_score", score_cnt - score_base, 0);
        hit_bar = 1'b0; step(1);

        // Asynchronous reset between edges.
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_lives", lives, 3);
        check("async_ben", ball_enable, 0);
        step(2);
        check("async_no_start", start, 0);
        reset = 1'b1; step(2);
        check("post_reset_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
